// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM states,
// arbitration mode codes, the default timeout error word and a sizing helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int ARB_RR    = 0;  // round-robin between m0 and m1
  localparam int ARB_FIXED = 1;  // m0 always wins a tie; m1 can starve

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Width of the timeout counter; at least one bit so TIMEOUT=0 still elaborates.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// 2-way grant logic: a lone requester always wins; on a tie, round-robin
// picks the master not granted last, fixed priority picks m0.
module mem_bus_arbiter_arb_rr2 (
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       last,
  output logic       gnt
);

  // Combinational winner selection; gnt is only consumed when req != 0.
  always_comb begin
    gnt = last;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = fixed_prio ? 1'b0 : ~last;
      default: gnt = last;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the native valid/ready memory bus. One transaction
// in flight: IDLE (arbitrate + latch payload) -> BUSY (slave request held,
// timeout counting) -> DONE (ready pulse to the owner) -> IDLE.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int          ARB_MODE  = ARB_RR,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        grant,
  output logic        busy,
  output logic        err
);

  localparam int            CW         = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic          FIXED_PRIO = (ARB_MODE == ARB_FIXED);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arb_gnt;
  logic          timeout_hit;

  mem_bus_arbiter_arb_rr2 u_arb (
    .req        ({m1_valid, m0_valid}),
    .fixed_prio (FIXED_PRIO),
    .last       (grant_q),
    .gnt        (arb_gnt)
  );

  // Timeout fires on the last allowed BUSY cycle; s_ready takes precedence below.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Next-state, payload capture, response routing and timeout counting.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = ST_BUSY;
          grant_d = arb_gnt;
          cnt_d   = '0;
          if (arb_gnt) begin
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            wstrb_d = m1_wstrb;
          end else begin
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            wstrb_d = m0_wstrb;
          end
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          state_d = ST_DONE;
          if (grant_q) begin
            m1_rdata_d = s_rdata;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = s_rdata;
            m0_ready_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (grant_q) begin
            m1_rdata_d = ERR_RDATA;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = ERR_RDATA;
            m0_ready_d = 1'b1;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, grant points at m1
  // so the first round-robin tie goes to m0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign s_valid  = (state_q == ST_BUSY);
  assign busy     = (state_q != ST_IDLE);
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign grant    = grant_q;
  assign err      = err_q;

endmodule
